// File: rtl/operand_fetch.sv
// Operand fetch / ID-EX boundary for a 5-stage pipeline.
// Selects the A/B operands for the instruction in ID from the register file
// or one of the EX/MEM/WB bypass paths. It detects hazards that need a stall
// and registers the accepted instruction into the EX stage.
module operand_fetch #(
   parameter int FWD_EN = 1
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        id_valid,
   input  logic        id_wreg,
   input  logic        id_load,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_dst,
   input  logic        flush,
   output logic [4:0]  rna,
   output logic [4:0]  rnb,
   input  logic [31:0] qa,
   input  logic [31:0] qb,
   input  logic [31:0] ex_res,
   input  logic [31:0] mem_res,
   input  logic [31:0] wb_d,
   input  logic [4:0]  wb_wn,
   input  logic        wb_we,
   output logic        stall,
   output logic        ex_valid,
   output logic        ex_wreg,
   output logic        ex_load,
   output logic [4:0]  ex_dst,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b
);

   localparam bit fwd = (FWD_EN != 0);

   typedef struct packed {
      logic       valid;
      logic       wreg;
      logic       load;
      logic [4:0] dst;
   } tag_t;

   tag_t            ex_reg, ex_next, mem_reg;
   logic [31:0]     ex_a_reg, ex_a_next, ex_b_reg, ex_b_next;
   logic [1:0][4:0]  src;
   logic [1:0][31:0] rf_q;
   logic [1:0][31:0] opnd;
   logic [1:0]       haz;
   logic             accept;

   // The MEM load flag is carried for completeness but no selection needs it.
   logic unused_mem_load;
   assign unused_mem_load = mem_reg.load;

   // Register-file read addresses come straight from the ID source fields.
   assign rna = id_rs;
   assign rnb = id_rt;

   // Index 0 is source A (rs/qa), index 1 is source B (rt/qb).
   assign src  = {id_rt, id_rs};
   assign rf_q = {qb, qa};

   // Per-source match, operand selection and hazard detection.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic nz, ex_hit, mem_hit, wb_hit;
         assign nz      = (src[gi] != 5'd0);
         assign ex_hit  = nz && ex_reg.valid && ex_reg.wreg && (ex_reg.dst == src[gi]);
         assign mem_hit = nz && mem_reg.valid && mem_reg.wreg && (mem_reg.dst == src[gi]);
         assign wb_hit  = nz && wb_we && (wb_wn == src[gi]);
         // Youngest producer wins; a load in EX has no data yet.
         assign opnd[gi] = !nz                             ? 32'd0   :
                           (fwd && ex_hit && !ex_reg.load) ? ex_res  :
                           (fwd && mem_hit)                ? mem_res :
                           wb_hit                          ? wb_d    :
                                                             rf_q[gi];
         // With forwarding only load-use stalls; without it any EX/MEM producer does.
         assign haz[gi] = fwd ? (ex_hit && ex_reg.load) : (ex_hit || mem_hit);
      end
   endgenerate

   // A flushed or absent ID instruction never stalls.
   assign stall  = id_valid && !flush && (|haz);
   assign accept = id_valid && !flush && !stall;

   // Next EX stage: accepted instruction, or a bubble that keeps dst/data.
   always_comb begin
      ex_next       = ex_reg;
      ex_next.valid = 1'b0;
      ex_next.wreg  = 1'b0;
      ex_next.load  = 1'b0;
      ex_a_next     = ex_a_reg;
      ex_b_next     = ex_b_reg;
      if (accept) begin
         ex_next   = '{valid: 1'b1, wreg: id_wreg, load: id_load, dst: id_dst};
         ex_a_next = opnd[0];
         ex_b_next = opnd[1];
      end
   end

   // EX/MEM stage registers; MEM always follows EX.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ex_reg   <= '0;
         mem_reg  <= '0;
         ex_a_reg <= '0;
         ex_b_reg <= '0;
      end else begin
         ex_reg   <= ex_next;
         mem_reg  <= ex_reg;
         ex_a_reg <= ex_a_next;
         ex_b_reg <= ex_b_next;
      end
   end

   assign ex_valid = ex_reg.valid;
   assign ex_wreg  = ex_reg.wreg;
   assign ex_load  = ex_reg.load;
   assign ex_dst   = ex_reg.dst;
   assign ex_a     = ex_a_reg;
   assign ex_b     = ex_b_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: runs a forwarding (FWD_EN=1) and a stalling
// (FWD_EN=0) instance on shared stimulus, checked by a scoreboard against a
// per-instance pipeline history model.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        clrn = 1'b1;
   logic        id_valid, id_wreg, id_load, flush, wb_we;
   logic [4:0]  id_rs, id_rt, id_dst, wb_wn;
   logic [31:0] qa, qb, ex_res, mem_res, wb_d;

   logic [4:0]  rna1, rnb1, rna0, rnb0, exd1, exd0;
   logic        stall1, stall0, exv1, exv0, exw1, exw0, exl1, exl0;
   logic [31:0] exa1, exb1, exa0, exb0;

   always #5 clk = ~clk;

   operand_fetch #(.FWD_EN(1)) dut1 (
      .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_wreg(id_wreg), .id_load(id_load),
      .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .flush(flush), .rna(rna1), .rnb(rnb1),
      .qa(qa), .qb(qb), .ex_res(ex_res), .mem_res(mem_res), .wb_d(wb_d), .wb_wn(wb_wn),
      .wb_we(wb_we), .stall(stall1), .ex_valid(exv1), .ex_wreg(exw1), .ex_load(exl1),
      .ex_dst(exd1), .ex_a(exa1), .ex_b(exb1));

   operand_fetch #(.FWD_EN(0)) dut0 (
      .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_wreg(id_wreg), .id_load(id_load),
      .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .flush(flush), .rna(rna0), .rnb(rnb0),
      .qa(qa), .qb(qb), .ex_res(ex_res), .mem_res(mem_res), .wb_d(wb_d), .wb_wn(wb_wn),
      .wb_we(wb_we), .stall(stall0), .ex_valid(exv0), .ex_wreg(exw0), .ex_load(exl0),
      .ex_dst(exd0), .ex_a(exa0), .ex_b(exb0));

   typedef struct packed { logic v; logic w; logic l; logic [4:0] d; } tag_t;
   typedef struct packed { logic w; logic l; logic [4:0] d; logic [31:0] a; logic [31:0] b; } exp_t;

   int   total = 0;
   int   bad   = 0;
   tag_t hist [2][2];      // [instance][age]: age 0 = issued last edge, age 1 = the edge before
   exp_t sbq0 [$];
   exp_t sbq1 [$];
   exp_t e0, e1;

   task automatic chk(string nm, logic [79:0] act, logic [79:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   function automatic logic hit(tag_t t, logic [4:0] s);
      return t.v && t.w && (t.d == s) && (s != 5'd0);
   endfunction

   // Value the instruction in ID should receive for source s.
   function automatic logic [31:0] model_opnd(int k, logic [4:0] s, logic [31:0] q);
      if (s == 5'd0) return 32'd0;
      if (k == 1 && hit(hist[k][0], s) && !hist[k][0].l) return ex_res;
      if (k == 1 && hit(hist[k][1], s)) return mem_res;
      if (wb_we && wb_wn == s) return wb_d;
      return q;
   endfunction

   function automatic logic model_stall(int k);
      if (!id_valid || flush) return 1'b0;
      if (k == 1)
         return hist[k][0].l && (hit(hist[k][0], id_rs) || hit(hist[k][0], id_rt));
      return hit(hist[k][0], id_rs) || hit(hist[k][0], id_rt) ||
             hit(hist[k][1], id_rs) || hit(hist[k][1], id_rt);
   endfunction

   // Called at posedge+1 with inputs set: check stall, predict, advance one edge.
   task automatic step();
      logic es, acc;
      exp_t e;
      #1;
      chk("rna", 80'(rna1), 80'(id_rs));
      chk("rnb", 80'(rnb0), 80'(id_rt));
      for (int k = 0; k < 2; k++) begin
         es = model_stall(k);
         chk($sformatf("stall%0d", k), 80'((k == 1) ? stall1 : stall0), 80'(es));
         acc = id_valid && !flush && !es;
         if (acc) begin
            e = {id_wreg, id_load, id_dst, model_opnd(k, id_rs, qa), model_opnd(k, id_rt, qb)};
            if (k == 1) sbq1.push_back(e); else sbq0.push_back(e);
         end
         hist[k][1] = hist[k][0];
         hist[k][0] = acc ? {1'b1, id_wreg, id_load, id_dst} : tag_t'(0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_wreg = 0; id_load = 0; flush = 0;
      id_rs = 0; id_rt = 0; id_dst = 0;
      qa = 0; qb = 0; ex_res = 0; mem_res = 0; wb_d = 0; wb_wn = 0; wb_we = 0;
   endtask

   task automatic issue(logic w, logic l, logic [4:0] rs, logic [4:0] rt, logic [4:0] dst);
      id_valid = 1; id_wreg = w; id_load = l; flush = 0;
      id_rs = rs; id_rt = rt; id_dst = dst;
   endtask

   // Asynchronous reset pulse with ID traffic present; returns at posedge+1.
   task automatic do_reset();
      clrn = 1'b0;
      #1;
      chk("rst_out1", 80'({exv1, exw1, exl1, exd1, exa1, exb1}), 80'(0));
      chk("rst_out0", 80'({exv0, exw0, exl0, exd0, exa0, exb0}), 80'(0));
      chk("rst_stall", 80'({stall1, stall0}), 80'(0));
      for (int k = 0; k < 2; k++) begin
         hist[k][0] = '0;
         hist[k][1] = '0;
      end
      sbq0.delete();
      sbq1.delete();
      issue(1, 1, 3, 4, 5);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_hold_valid", 80'({exv1, exv0, stall1, stall0}), 80'(0));
      end
      clrn = 1'b1;
      idle();
   endtask

   // Monitor: every presented EX instruction must be the oldest expected one.
   always @(negedge clk) begin
      if (clrn && exv1) begin
         if (sbq1.size() == 0) chk("ex_valid1_spurious", 80'(exv1), 80'(0));
         else begin
            e1 = sbq1.pop_front();
            chk("ex1", 80'({exw1, exl1, exd1, exa1, exb1}), 80'(e1));
         end
      end
      if (clrn && exv0) begin
         if (sbq0.size() == 0) chk("ex_valid0_spurious", 80'(exv0), 80'(0));
         else begin
            e0 = sbq0.pop_front();
            chk("ex0", 80'({exw0, exl0, exd0, exa0, exb0}), 80'(e0));
         end
      end
   end

   initial begin
      idle();
      #2;
      do_reset();

      // EX forwarding of an ALU result.
      issue(1, 0, 1, 2, 5); qa = 32'h100; qb = 32'h200; step();
      issue(1, 0, 5, 0, 6); qa = 32'h0; ex_res = 32'h11; step();
      chk("fwd_ex_a", 80'(exa1), 80'(32'h11));

      // Load-use: one bubble, then the MEM path supplies the load data.
      do_reset();
      issue(1, 1, 1, 2, 8); qa = 32'h5; qb = 32'h6; step();
      issue(1, 0, 0, 8, 9); #1; chk("lu_stall", 80'(stall1), 80'(1)); step();
      chk("lu_bubble", 80'(exv1), 80'(0));
      mem_res = 32'hABCD; step();
      chk("lu_ex_b", 80'(exb1), 80'(32'hABCD));

      // Priority EX > MEM > WB for the same register.
      for (int v = 0; v < 3; v++) begin
         do_reset();
         if (v < 2) issue(1, 0, 1, 2, 3); else idle();
         step();
         if (v == 0) issue(1, 0, 1, 2, 3); else idle();
         step();
         issue(0, 0, 3, 0, 9);
         ex_res = 32'd1; mem_res = 32'd2; wb_we = 1; wb_wn = 3; wb_d = 32'd3; qa = 32'h77;
         step();
         chk($sformatf("prio%0d", v), 80'(exa1), 80'(32'(v + 1)));
      end

      // Register 0 never forwards.
      do_reset();
      issue(1, 0, 1, 2, 0); step();
      issue(1, 0, 0, 0, 4); ex_res = 32'hFFFF; step();
      chk("r0_ex_a", 80'({exv1, exa1}), 80'({1'b1, 32'h0}));

      // Flush beats a load-use stall; EX fields hold under the bubble.
      do_reset();
      issue(1, 1, 1, 2, 8); step();
      issue(1, 0, 0, 8, 4); flush = 1; step();
      chk("flush_bubble", 80'({exv1, exv0}), 80'(0));
      chk("flush_hold_dst", 80'(exd1), 80'(8));

      // No-forwarding instance: MEM hazard stall, then WB bypass.
      do_reset();
      issue(1, 0, 1, 2, 7); step();
      idle(); step();
      issue(0, 0, 7, 0, 9); step();
      wb_we = 1; wb_wn = 7; wb_d = 32'h55; step();
      chk("nofwd_wb_a", 80'(exa0), 80'(32'h55));
      // Reset pulse while the no-forwarding instance is stalled.
      do_reset();
      issue(1, 0, 1, 2, 7); step();
      issue(0, 0, 7, 0, 9); #1;
      chk("nofwd_stall", 80'(stall0), 80'(1));
      do_reset();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         id_valid = ($urandom_range(0, 3) != 0);
         id_wreg  = ($urandom_range(0, 3) != 0);
         id_load  = ($urandom_range(0, 3) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         id_rs    = 5'($urandom_range(0, 7));
         id_rt    = 5'($urandom_range(0, 7));
         id_dst   = 5'($urandom_range(0, 7));
         qa       = (id_rs == 5'd0) ? 32'd0 : $urandom;
         qb       = (id_rt == 5'd0) ? 32'd0 : $urandom;
         ex_res   = $urandom;
         mem_res  = $urandom;
         wb_d     = $urandom;
         wb_we    = ($urandom_range(0, 1) != 0);
         wb_wn    = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 299) == 0) do_reset();
         step();
      end

      idle();
      repeat (3) step();
      chk("sb1_drained", 80'(sbq1.size()), 80'(0));
      chk("sb0_drained", 80'(sbq0.size()), 80'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter FWD_EN, default 1: 1 = bypass from EX/MEM/WB; 0 = stall on any EX/MEM hazard, bypass from WB only.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have ports id_valid, id_wreg, id_load  input  1 each  ID instruction present, writes a register, is a load.
REQ-005 SHALL have ports id_rs, id_rt, id_dst  input  5 each  source A, source B and destination register numbers.
REQ-006 SHALL have port flush  input  1  kill the ID instruction this cycle (taken branch).
REQ-007 SHALL have ports rna, rnb  output  5 each  register-file read addresses; combinationally equal to id_rs, id_rt.
REQ-008 SHALL have ports qa, qb  input  32 each  register-file read data; register 0 reads 0.
REQ-009 SHALL have ports ex_res, mem_res  input  32 each  ALU result of the tracked EX instruction; result or load data of the tracked MEM instruction.
REQ-010 SHALL have ports wb_d  input 32, wb_wn  input 5, wb_we  input 1  write-back bus, also driven to the register file.
REQ-011 SHALL have port stall  output  1  upstream holds PC and ID.
REQ-012 SHALL have ports ex_valid, ex_wreg, ex_load  output 1 each; ex_dst  output 5; ex_a, ex_b  output 32 each  registered ID/EX stage.

Function
REQ-013 SHALL track two stages internally: EX {valid, wreg, load, dst} (driven out as ex_*) and MEM {valid, wreg, load, dst}; MEM <= EX every cycle unconditionally.
REQ-014 A stage SHALL match source s when valid && wreg && dst == s && s != 0; register 0 never matches, never forwards, and reads as 0.
REQ-015 Operand for source s (FWD_EN=1), priority order: EX match and !ex_load -> ex_res; else MEM match -> mem_res; else wb_we && wb_wn == s && s != 0 -> wb_d; else qa/qb.
REQ-016 FWD_EN=0: EX or MEM match SHALL assert stall; the WB bypass SHALL still apply.
REQ-017 FWD_EN=1: stall SHALL be 1 when id_valid && !flush && EX stage is a load matching id_rs or id_rt (load-use, exactly one bubble).
REQ-018 stall SHALL be combinational and forced 0 when flush=1 or id_valid=0.
REQ-019 On each edge: if id_valid && !flush && !stall, EX <= {1, id_wreg, id_load, id_dst} and ex_a/ex_b <= selected operands; otherwise EX valid/wreg/load <= 0 (bubble), with ex_dst, ex_a, ex_b holding.
REQ-020 Latency SHALL be one cycle from an ID accept to ex_valid=1.
REQ-021 flush SHALL take priority over stall in the same cycle.
REQ-022 A source matching both EX and MEM SHALL take the EX value (youngest wins); a source matching MEM and WB SHALL take mem_res.

Reset
REQ-023 clrn=0 SHALL immediately clear EX and MEM stage state: ex_valid, ex_wreg, ex_load = 0, ex_dst = 0, ex_a = ex_b = 0.
REQ-024 While clrn=0, stall SHALL be 0 and ex_valid SHALL stay 0 regardless of id_valid.
REQ-025 Reset asserted mid-operation SHALL discard in-flight EX/MEM tags; the first edge after release SHALL behave as a cold start.

Verification
REQ-026 EX forwarding: EX = {wreg, dst=5, ex_res=0x11}; ID rs=5, qa=0 -> ex_a = 0x11 next edge, stall=0.
REQ-027 Load-use: EX = {load, dst=8}; ID rt=8 -> stall=1 for one cycle and a bubble; next cycle MEM matches, mem_res=0xABCD -> ex_b = 0xABCD.
REQ-028 Priority: EX dst=3 (ex_res=1), MEM dst=3 (mem_res=2), wb_wn=3 (wb_d=3) -> ex_a = 1; with EX invalid -> 2; with EX and MEM invalid -> 3.
REQ-029 Register 0: EX dst=0, wreg=1, ex_res=0xFFFF; ID rs=0 -> ex_a = 0, no stall.
REQ-030 Flush and stall together: load-use condition with flush=1 -> stall=0, ex_valid=0 next edge.
REQ-031 FWD_EN=0: MEM dst=7 matches rs=7 -> stall=1 one cycle; next cycle WB bypass wb_d=0x55 -> ex_a = 0x55; clrn pulse mid-stall -> ex_valid=0 and stall=0 at once.
